// File: rtl/mod_calc_pkg.sv
// ---------------------------------------------------------------------------
// mod_calc_pkg
// Shared definitions for the modular-calc residue blocks.
//   state_t       : FSM state encoding used by the sequential multipliers
//   res_width()   : residue width needed to hold 0..mod-1
//   const_reduce(): reduces a constant multiplier into the residue range
// ---------------------------------------------------------------------------
package mod_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to represent every residue 0..mod-1.
    function automatic int res_width(input int mod);
        return $clog2(mod);
    endfunction

    // K = mult mod mod; a zero modulus is rejected by the instantiating
    // block, so it only has to avoid a divide-by-zero here.
    function automatic int const_reduce(input int mult, input int mod);
        return (mod > 0) ? (mult % mod) : 0;
    endfunction

endpackage

// File: rtl/mod_dbl_add.sv
// ---------------------------------------------------------------------------
// mod_dbl_add
// Combinational residue step: sum = (2*acc + b*K) mod MOD.
// Two conditional subtractions are enough because acc < MOD and K < MOD,
// so every intermediate stays below 2*MOD and fits in RES_W+1 bits.
// Ports:
//   acc  in  RES_W  current accumulator, 0..MOD-1
//   b    in  1      operand bit for this step
//   sum  out RES_W  next accumulator, 0..MOD-1
// ---------------------------------------------------------------------------
module mod_dbl_add #(
    parameter int MOD   = 53,
    parameter int K     = 37,
    parameter int RES_W = 6
) (
    input  logic [RES_W-1:0] acc,
    input  logic             b,
    output logic [RES_W-1:0] sum
);

    localparam logic [RES_W:0] MOD_V = (RES_W+1)'(MOD);
    localparam logic [RES_W:0] K_V   = (RES_W+1)'(K);

    logic [RES_W:0] dbl;
    logic [RES_W:0] dbl_r;
    logic [RES_W:0] sum_t;

    // Double, fold back once, conditionally add K, fold back once more.
    always_comb begin
        dbl   = {acc, 1'b0};
        dbl_r = (dbl >= MOD_V) ? (dbl - MOD_V) : dbl;
        sum_t = dbl_r + (b ? K_V : '0);
        sum   = RES_W'((sum_t >= MOD_V) ? (sum_t - MOD_V) : sum_t);
    end

endmodule

// File: rtl/mod_const_mul_seq.sv
// ---------------------------------------------------------------------------
// mod_const_mul_seq
// Sequential residue constant multiplier: z = (x * MULT) mod MOD, one
// operand bit per cycle, MSB first (Horner: acc = 2*acc + b*K mod MOD).
// Operands wider than the modulus are handled exactly; no pre-reduction.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand present
//   in_ready   out  1      idle, able to accept
//   in_x       in   IN_W   unsigned operand
//   out_valid  out  1      result present
//   out_ready  in   1      downstream accepts result
//   out_z      out  RES_W  result, 0..MOD-1
//   busy       out  1      high while in the BUSY state
//
// Optional feature macro: MODMUL_SKIP_LZ_EN
//   When defined, leading zero bits of the operand are skipped: the bit
//   counter starts at the index of the highest set bit (0 for x = 0).
//   Results are identical; only the latency changes.
// ---------------------------------------------------------------------------
module mod_const_mul_seq
    import mod_calc_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int MOD   = 53,
    parameter int MULT  = 37,
    localparam int RES_W = res_width(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_z,
    output logic             busy
);

    localparam int K     = const_reduce(MULT, MOD);
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(IN_W - 1);

    if (MOD < 2) begin : g_bad_mod
        $error("mod_const_mul_seq: MOD must be >= 2");
    end

    state_t            state;
    logic [IN_W-1:0]   shreg;
    logic [CNT_W-1:0]  cnt;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  acc_next;
    logic [RES_W-1:0]  z_q;
    logic [CNT_W-1:0]  start_cnt;
    logic [IN_W-1:0]   start_sh;

    // The step logic always consumes the top of the shift register, so the
    // operand is MSB-aligned on load and shifted left once per BUSY cycle.
    mod_dbl_add #(
        .MOD   (MOD),
        .K     (K),
        .RES_W (RES_W)
    ) u_step (
        .acc (acc),
        .b   (shreg[IN_W-1]),
        .sum (acc_next)
    );

`ifdef MODMUL_SKIP_LZ_EN
    // Priority encoder: index of the highest set bit, 0 when in_x is zero.
    always_comb begin
        start_cnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in_x[i]) begin
                start_cnt = i[CNT_W-1:0];
            end
        end
    end

    // Shift the leading zeros out so the first processed bit is the top one.
    assign start_sh = in_x << (TOP_IDX - start_cnt);
`else
    assign start_cnt = TOP_IDX;
    assign start_sh  = in_x;
`endif

    // Control FSM together with the datapath registers. The final step
    // result is copied into z_q so out_z stays stable through backpressure
    // and is only cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            acc   <= '0;
            z_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= start_sh;
                        cnt   <= start_cnt;
                        acc   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        z_q   <= acc_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the registered state, so there is
    // no combinational path from in_valid or out_ready to them.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign out_z     = z_q;

endmodule

// File: tb/tb_mod_const_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mod_const_mul_seq
// Self-checking bench for mod_const_mul_seq. Three instances:
//   dut   : IN_W=9, MOD=53, MULT=37
//   dut_b : IN_W=9, MOD=53, MULT=90 (reduces to the same K, shares inputs)
//   dut_s : IN_W=4, MOD=7,  MULT=3
// Expected results come from (x*MULT) mod MOD computed with integers.
// ---------------------------------------------------------------------------
module tb_mod_const_mul_seq;

    localparam int W  = 9;
    localparam int M  = 53;
    localparam int MU = 37;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [8:0] in_x;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_z;
    logic       busy;

    logic       b_in_ready;
    logic       b_out_valid;
    logic [5:0] b_out_z;
    logic       b_busy;

    logic       s_in_valid;
    logic [3:0] s_in_x;
    logic       s_out_ready;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [2:0] s_out_z;
    logic       s_busy;

    int checks;
    int errors;

    mod_const_mul_seq #(.IN_W(W), .MOD(M), .MULT(MU)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .busy      (busy)
    );

    mod_const_mul_seq #(.IN_W(W), .MOD(M), .MULT(90)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_x      (in_x),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_z     (b_out_z),
        .busy      (b_busy)
    );

    mod_const_mul_seq #(.IN_W(4), .MOD(7), .MULT(3)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_x      (s_in_x),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_z     (s_out_z),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected number of BUSY cycles for operand x on a w-bit instance.
    function automatic int exp_lat(input int x, input int w);
`ifdef MODMUL_SKIP_LZ_EN
        int n;
        n = 1;
        for (int v = x; v > 1; v = v / 2) n++;
        return n;
`else
        if (x < 0) return 0;
        return w;
`endif
    endfunction

    function automatic logic [5:0] model_z(input int x);
        return 6'((x * MU) % M);
    endfunction

    // One full transaction on dut/dut_b: accept, wait for result with random
    // in_valid noise while busy, hold for 'stall' cycles, then hand off.
    task automatic run_op(input int x, input logic [5:0] exp_z, input int stall);
        int lat;
        int k;
        lat = exp_lat(x, W);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept_ready x=%0d got=%b exp=1", x, in_ready);
        end
        in_x      = 9'(x);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_flags x=%0d cyc=%0d busy=%b in_ready=%b exp busy=1 in_ready=0",
                         x, k, busy, in_ready);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_x     = 9'($urandom);
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        checks++;
        if (k != lat) begin
            errors++;
            $display("[TB] FAIL latency x=%0d got=%0d exp=%0d", x, k, lat);
        end
        checks++;
        if (out_z !== exp_z) begin
            errors++;
            $display("[TB] FAIL result x=%0d got=%0d exp=%0d", x, out_z, exp_z);
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_z !== exp_z) begin
            errors++;
            $display("[TB] FAIL mult90 x=%0d valid=%b got=%0d exp=%0d", x, b_out_valid, b_out_z, exp_z);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_z !== exp_z || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold x=%0d valid=%b z=%0d in_ready=%b exp valid=1 z=%0d in_ready=0",
                         x, out_valid, out_z, in_ready, exp_z);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release x=%0d valid=%b in_ready=%b exp valid=0 in_ready=1",
                     x, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_x        = '0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_x      = '0;
        s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_z !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_state in_ready=%b out_valid=%b busy=%b out_z=%0d exp 1/0/0/0",
                     in_ready, out_valid, busy, out_z);
        end
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_z !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_small in_ready=%b out_valid=%b out_z=%0d exp 1/0/0",
                     s_in_ready, s_out_valid, s_out_z);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        run_op(1,   6'd37, 0);
        run_op(2,   6'd21, 0);
        run_op(399, 6'd29, 0);
        run_op(511, 6'd39, 0);
        run_op(53,  6'd0,  0);
        run_op(0,   6'd0,  0);
        run_op(256, 6'd38, 0);
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        in_x      = 9'd399;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_z !== 6'd29 || in_ready !== 1'b0 || b_out_z !== 6'd29) begin
                errors++;
                $display("[TB] FAIL backpressure cyc=%0d valid=%b z=%0d bz=%0d in_ready=%b exp 1/29/29/0",
                         i, out_valid, out_z, b_out_z, in_ready);
            end
            in_valid = (i == 7);
            in_x     = 9'd1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_z !== 6'd29) begin
            errors++;
            $display("[TB] FAIL bp_ignored got=%0d exp=29", out_z);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release valid=%b in_ready=%b busy=%b exp 0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid_busy;
        run_op(511, 6'd39, 0);
        @(negedge clk);
        in_x     = 9'd399;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_z !== 6'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset valid=%b z=%0d in_ready=%b busy=%b exp 0/0/1/0",
                     out_valid, out_z, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(2, 6'd21, 0);
    endtask

    task automatic test_exhaustive;
        for (int x = 0; x < 512; x++) begin
            run_op(x, model_z(x), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_back_to_back;
        int x;
        for (int n = 0; n < 24; n++) begin
            x = int'($urandom_range(0, 511));
            run_op(x, model_z(x), 0);
        end
    endtask

    task automatic test_small;
        int k;
        logic [2:0] exp_z;
        s_out_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            exp_z = 3'((x * 3) % 7);
            @(negedge clk);
            s_in_x     = 4'(x);
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            k = 0;
            while (s_out_valid !== 1'b1 && k < 30) begin
                @(posedge clk);
                #1;
                k++;
            end
            checks++;
            if (k != exp_lat(x, 4) || s_out_z !== exp_z) begin
                errors++;
                $display("[TB] FAIL small x=%0d lat=%0d exp_lat=%0d got=%0d exp=%0d",
                         x, k, exp_lat(x, 4), s_out_z, exp_z);
            end
            @(posedge clk);
            #1;
            checks++;
            if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL small_release x=%0d in_ready=%b valid=%b exp 1/0",
                         x, s_in_ready, s_out_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] start");
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_busy();
        test_exhaustive();
        test_back_to_back();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
